regfile_stream_ctrl: RTL
========================

REGFILE_STREAM_CTRL -- requirements
Module: regfile_stream_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths are fixed for the 8x8 register file (3-bit address, 8-bit data).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 cmd_op  input  1  0 = LOAD (stream in, write regs), 1 = DUMP (read regs, stream out).
REQ-007 cmd_base  input  3  first register address.
REQ-008 cmd_len  input  3  transfer length minus one (0 -> 1 byte, 7 -> 8 bytes).
REQ-009 in_valid / in_ready / in_data  input / output / input  1/1/8  LOAD byte stream.
REQ-010 out_valid / out_ready / out_data  output / input / output  1/1/8  DUMP byte stream.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 rf_write_en / rf_write_addr / rf_write_data  output  1/3/8  drive register file write port.
REQ-013 rf_read_addr / rf_read_data  output / input  3/8  drive one register file read port; read data is combinational from address.

Function
REQ-014 States SHALL be IDLE, LOAD, DUMP_RD, DUMP_OUT, with a 3-bit address pointer ptr and a 3-bit remaining counter rem.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a handshake (cmd_valid & cmd_ready) SHALL load ptr=cmd_base, rem=cmd_len, and go to LOAD (op 0) or DUMP_RD (op 1) on the next cycle.
REQ-016 In LOAD, in_ready SHALL be 1; in all other states 0.
REQ-017 In LOAD, rf_write_en SHALL equal in_valid, combinationally, with rf_write_addr=ptr and rf_write_data=in_data, so the byte is written on the same edge it is accepted.
REQ-018 rf_write_en SHALL be 0 in every state other than LOAD.
REQ-019 On each accepted LOAD byte: if rem==0 go to IDLE; otherwise ptr=ptr+1 modulo 8 (7 wraps to 0) and rem=rem-1.
REQ-020 rf_read_addr SHALL equal ptr in all states.
REQ-021 In DUMP_RD, out_data SHALL register rf_read_data on the clock edge and the state SHALL go to DUMP_OUT; out_valid is 0 in DUMP_RD.
REQ-022 In DUMP_OUT, out_valid SHALL be 1, and out_data SHALL stay stable until out_ready is sampled high.
REQ-023 On the DUMP_OUT handshake: if rem==0 go to IDLE; otherwise ptr=ptr+1 modulo 8, rem=rem-1, go to DUMP_RD. Each dumped byte therefore costs a minimum of 2 cycles.
REQ-024 A LOAD byte SHALL NOT be accepted in the cycle the command is accepted; the first possible acceptance is the cycle after.
REQ-025 in_valid while not in LOAD, out_ready while not in DUMP_OUT, and cmd_valid while busy SHALL have no effect.
REQ-026 Length 8 starting at any base SHALL touch each of the 8 registers exactly once.

Reset
REQ-027 When reset is high at a clock edge, the next state SHALL be IDLE, with ptr=0, rem=0 and out_data=0x00.
REQ-028 While reset is high, cmd_ready, in_ready, out_valid, busy and rf_write_en SHALL all be forced to 0 combinationally.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer. No further register writes SHALL occur, and registers already written keep their values.
REQ-030 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-031 LOAD, base=0, len=7, bytes 0x10..0x17 with in_valid held high -> 8 consecutive write cycles to addresses 0..7, then busy=0 on the next cycle.
REQ-032 DUMP, base=0, len=7, after REQ-031, out_ready held high -> out_data sequence 0x10..0x17, with out_valid high every other cycle.
REQ-033 LOAD, base=6, len=2, bytes 0xA6,0xA7,0xA0 -> writes to addresses 6, 7, 0 (wrap); a DUMP of base=6, len=2 returns the same bytes.
REQ-034 DUMP with out_ready held low for 5 cycles -> out_valid stays 1 and out_data is unchanged for those cycles; the pointer does not advance.
REQ-035 LOAD, len=7, reset asserted after 3 bytes -> exactly 3 writes occur; state is IDLE and cmd_ready=1 after reset releases; the previously written registers are intact on a subsequent DUMP.
REQ-036 cmd_valid pulsed during an active DUMP, and in_valid high during DUMP -> the command is ignored, no writes occur, and the DUMP output is unaffected.

Source files
------------

// File: rtl/regfile_stream_ctrl.sv
// regfile_stream_ctrl: streams bytes between cmd/in/out handshakes and an 8x8 register file (one write port, one combinational read port).
module regfile_stream_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [2:0] cmd_base,
  input  logic [2:0] cmd_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       rf_write_en,
  output logic [2:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  output logic [2:0] rf_read_addr,
  input  logic [7:0] rf_read_data
);
  typedef enum logic [1:0] {IDLE, LOAD, DUMP_RD, DUMP_OUT} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, rem, rem_n;
  logic [7:0] data_n;
  logic step;
  assign step = (state == LOAD && in_valid) || (state == DUMP_OUT && out_ready);
  assign cmd_ready = !reset && state == IDLE;
  assign in_ready = !reset && state == LOAD;
  assign out_valid = !reset && state == DUMP_OUT;
  assign busy = !reset && state != IDLE;
  assign rf_write_en = !reset && state == LOAD && in_valid;
  assign rf_write_addr = ptr;
  assign rf_write_data = in_data;
  assign rf_read_addr = ptr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= 3'd0;
      rem <= 3'd0;
      out_data <= 8'h00;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      rem <= rem_n;
      out_data <= data_n;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    rem_n = rem;
    data_n = out_data;
    case (state)
      IDLE: if (cmd_valid) begin
        state_n = cmd_op ? DUMP_RD : LOAD;
        ptr_n = cmd_base;
        rem_n = cmd_len;
      end
      LOAD: if (in_valid) state_n = rem == 3'd0 ? IDLE : LOAD;
      DUMP_RD: begin
        state_n = DUMP_OUT;
        data_n = rf_read_data;
      end
      DUMP_OUT: if (out_ready) state_n = rem == 3'd0 ? IDLE : DUMP_RD;
      default: state_n = IDLE;
    endcase
    if (step && rem != 3'd0) begin
      ptr_n = ptr + 3'd1;
      rem_n = rem - 3'd1;
    end
  end
endmodule
